// File: rtl/fft_pipe_pkg.sv
// Shared definitions for the Radix-5 FFT inter-stage datapath.
//   CPLX_W      : width of one real or imaginary component
//   CPLX_NCH    : complex channels per beat
//   BEAT_W      : packed width of one re (or im) bus
//   cplx_beat_t : packed re/im beat, shared with the butterfly modules
//   ch_slice()  : extracts channel c from a packed re or im bus
package fft_pipe_pkg;

  localparam int CPLX_W   = 32;
  localparam int CPLX_NCH = 3;
  localparam int BEAT_W   = CPLX_W * CPLX_NCH;

  typedef struct packed {
    logic [BEAT_W-1:0] re;
    logic [BEAT_W-1:0] im;
  } cplx_beat_t;

  // Channel c lives at [c*CPLX_W +: CPLX_W].
  function automatic logic [CPLX_W-1:0] ch_slice(input logic [BEAT_W-1:0] bus,
                                                 input int unsigned c);
    return bus[c*CPLX_W +: CPLX_W];
  endfunction

endpackage

// File: rtl/fft_pipe_stage.sv
// One register stage of the elastic FFT pipeline buffer.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : stage advance enable (built by the parent's ready chain)
//   flush         : synchronous clear of the valid bit
//   vld_in        : valid of the beat offered from upstream
//   re_in, im_in  : data offered from upstream
//   vld, re, im   : registered stage contents
// Data registers only load when a valid beat actually moves in, so bubbles
// never toggle the wide data path.
module fft_pipe_stage
  import fft_pipe_pkg::*;
#(
  parameter int BW = BEAT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          vld_in,
  input  logic [BW-1:0] re_in,
  input  logic [BW-1:0] im_in,
  output logic          vld,
  output logic [BW-1:0] re,
  output logic [BW-1:0] im
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      re  <= '0;
      im  <= '0;
    end else begin
      if (flush)   vld <= 1'b0;
      else if (en) vld <= vld_in;
      if (en && vld_in) begin
        re <= re_in;
        im <= im_in;
      end
    end
  end

endmodule

// File: rtl/fft_pipe_buf.sv
// Elastic pipeline buffer carrying NCH complex samples through DEPTH stages.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous discard of every buffered beat
//   in_valid / in_ready   : upstream handshake, in_re/in_im packed per channel
//   out_valid / out_ready : downstream handshake, out_re/out_im from last stage
//   occupancy             : number of valid stages (popcount of stage valids)
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; ready may depend combinationally on the other side's ready, valid
// never depends on ready. in_ready is forced low during flush, so a beat
// offered in a flush cycle is dropped, while the output beat of that cycle
// still completes if out_ready is high.
// The ready chain runs combinationally from the output back to stage 0, so an
// empty stage always loads and a stall compacts gaps (bubble collapse).
module fft_pipe_buf
  import fft_pipe_pkg::*;
#(
  parameter int W     = CPLX_W,
  parameter int NCH   = CPLX_NCH,
  parameter int DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W*NCH-1:0]           in_re,
  input  logic [W*NCH-1:0]           in_im,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W*NCH-1:0]           out_re,
  output logic [W*NCH-1:0]           out_im,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int BW    = W * NCH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] en;
  logic [BW-1:0]    re_q [DEPTH];
  logic [BW-1:0]    im_q [DEPTH];
  logic [OCC_W-1:0] occ_c;

  // A stage advances when it is empty or its successor takes its beat.
  always_comb begin
    en = '0;
    en[DEPTH-1] = ~vld[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      en[k] = ~vld[k] | en[k+1];
    end
  end

  assign in_ready = en[0] & ~flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          s_vld;
    logic [BW-1:0] s_re;
    logic [BW-1:0] s_im;

    if (k == 0) begin : g_head
      assign s_vld = in_valid & ~flush;
      assign s_re  = in_re;
      assign s_im  = in_im;
    end else begin : g_body
      assign s_vld = vld[k-1];
      assign s_re  = re_q[k-1];
      assign s_im  = im_q[k-1];
    end

    fft_pipe_stage #(.BW(BW)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en[k]),
      .flush  (flush),
      .vld_in (s_vld),
      .re_in  (s_re),
      .im_in  (s_im),
      .vld    (vld[k]),
      .re     (re_q[k]),
      .im     (im_q[k])
    );
  end

  // Occupancy depends only on stage registers, never on inputs.
  always_comb begin
    occ_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_c = occ_c + OCC_W'(vld[k]);
    end
  end

  assign occupancy = occ_c;
  assign out_valid = vld[DEPTH-1];
  assign out_re    = re_q[DEPTH-1];
  assign out_im    = im_q[DEPTH-1];

endmodule

// File: tb/tb_fft_pipe_buf.sv
module tb_fft_pipe_buf;
  import fft_pipe_pkg::*;

  localparam int W     = 32;
  localparam int NCH   = 3;
  localparam int DEPTH = 3;
  localparam int BW    = W * NCH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BW-1:0]    in_re = '0;
  logic [BW-1:0]    in_im = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BW-1:0]    out_re;
  logic [BW-1:0]    out_im;
  logic [OCC_W-1:0] occupancy;

  fft_pipe_buf #(.W(W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .occupancy (occupancy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int nb    = 0;
  bit chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [2*BW-1:0] act, input logic [2*BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [2*BW-1:0] exp_q[$];
  int              lat_q[$];

  // Handshakes are evaluated mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back({in_re, in_im});
        lat_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h expected no beat", {out_re, out_im});
        end else begin
          logic [2*BW-1:0] e;
          int t;
          e = exp_q.pop_front();
          t = lat_q.pop_front();
          check("out_data", {out_re, out_im}, e);
          if (chk_lat) check("latency", 2*BW'(cyc - t), 2*BW'(DEPTH));
        end
      end
      // A flushed buffer loses every beat still stored.
      if (flush) begin
        exp_q.delete();
        lat_q.delete();
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [BW-1:0] mk_re(input int i);
    logic [BW-1:0] b;
    for (int c = 0; c < NCH; c++) b[c*W +: W] = W'(i) + W'(c * 32'h100);
    return b;
  endfunction

  function automatic logic [BW-1:0] mk_im(input int i);
    logic [BW-1:0] b;
    logic [BW-1:0] r;
    r = mk_re(i);
    for (int c = 0; c < NCH; c++) b[c*W +: W] = -r[c*W +: W];
    return b;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      for (int c = 0; c < NCH; c++) begin
        in_re[c*W +: W] = 32'hDEAD;
        in_im[c*W +: W] = 32'hDEAD;
      end
    end else begin
      in_re = mk_re(nb);
      in_im = mk_im(nb);
    end
    #1;
  endtask

  typedef struct {
    logic             iv;
    logic             ordy;
    logic             fl;
    logic             exp_ir;
    logic             exp_ov;
    logic [OCC_W-1:0] exp_occ;
  } step_t;

  step_t tbl[$];

  task automatic add(input logic iv, ordy, fl, ir, ov, input int occ);
    step_t s;
    s.iv = iv; s.ordy = ordy; s.fl = fl;
    s.exp_ir = ir; s.exp_ov = ov; s.exp_occ = OCC_W'(occ);
    tbl.push_back(s);
  endtask

  initial begin
    // Backpressure: 5 beats offered with out_ready=0, 3 stored, then full
    // pass-through while the rest drains.
    add(1,0,0, 1,0,0); add(1,0,0, 1,0,1); add(1,0,0, 1,0,2);
    add(1,0,0, 0,1,3); add(1,0,0, 0,1,3);
    add(1,1,0, 1,1,3); add(1,1,0, 1,1,3);
    add(0,1,0, 1,1,3); add(0,1,0, 1,1,2); add(0,1,0, 1,1,1); add(0,1,0, 1,0,0);
    // Bubbles on alternate cycles under stall compact to a full buffer.
    add(1,0,0, 1,0,0); add(0,0,0, 1,0,1); add(1,0,0, 1,0,1); add(0,0,0, 1,1,2);
    add(1,0,0, 1,1,2); add(0,0,0, 0,1,3);
    add(0,1,0, 1,1,3); add(0,1,0, 1,1,2); add(0,1,0, 1,1,1); add(0,1,0, 1,0,0);
    // Flush with two beats stored and 0xDEAD offered.
    add(1,0,0, 1,0,0); add(1,0,0, 1,0,1); add(1,0,1, 0,0,2);
    add(0,1,0, 1,0,0); add(0,1,0, 1,0,0);

    // Reset state
    #12;
    check("rst_out_valid", 2*BW'(out_valid), '0);
    check("rst_occupancy", 2*BW'(occupancy), '0);
    check("rst_out_data", {out_re, out_im}, '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 2*BW'(in_ready), 2*BW'(1));

    // Streaming at full rate with fixed latency
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0);
      check("stream_in_ready", 2*BW'(in_ready), 2*BW'(1));
      if (in_ready) nb++;
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 1, 0);
    chk_lat = 1'b0;
    check("stream_drained", 2*BW'(exp_q.size()), '0);

    // Table-driven corner sequences
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl);
      check($sformatf("tbl%0d_in_ready", i), 2*BW'(in_ready), 2*BW'(tbl[i].exp_ir));
      check($sformatf("tbl%0d_out_valid", i), 2*BW'(out_valid), 2*BW'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_occupancy", i), 2*BW'(occupancy), 2*BW'(tbl[i].exp_occ));
      if (in_valid && in_ready) nb++;
    end
    check("tbl_drained", 2*BW'(exp_q.size()), '0);

    // Reset mid-traffic: stored beats are lost at once
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      if (in_ready) nb++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 2*BW'(out_valid), '0);
    check("midrst_occupancy", 2*BW'(occupancy), '0);
    in_valid = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 2*BW'(in_ready), 2*BW'(1));
    drive(0, 1, 0);
    drive(0, 1, 0);
    check("midrst_no_out", 2*BW'(out_valid), '0);
    check("final_queue_empty", 2*BW'(exp_q.size()), '0);
    check("ch_slice_pkg", 2*BW'(ch_slice(mk_re(5), 1)), 2*BW'(32'h105));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
